gate_truth_checker: RTL and testbench

- Sequential stimulus driver and response checker for the lab's single-output combinational gates (myNot and sibling gate modules).
- Sits on the opposite side of the gate interface: drives the gate's inputs, samples its output, and compares each result against the expected truth table.
- Sweeps every input combination once per run and reports pass/fail, mismatch count, first failing vector and the captured truth table.

---
 rtl/gate_truth_checker.sv | 177 +++++++++++++++++
 tb/tb_gate_truth_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// ============================================================================
// Module   : gate_truth_checker
// Purpose  : Drives every input combination into a single-output gate, samples
//            its response and checks it against the expected truth table.
//            Optional macro STOP_ON_FAIL_EN ends the sweep at the first mismatch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gate_truth_checker #(
  parameter int N_IN    = 1,
  parameter int SETTLE  = 2,
  parameter int GATE_OP = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      stimulus,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        fail_count,
  output logic [N_IN-1:0]      first_fail_vec,
  output logic [2**N_IN-1:0]   table_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0]      c_settle_load = 4'(SETTLE);
  localparam logic [N_IN-1:0] c_vec_last    = '1;
  localparam logic [N_IN-1:0] c_vec_one     = N_IN'(1);
  localparam logic [N_IN:0]   c_fail_one    = (N_IN+1)'(1);

  state_t r_state;
  state_t w_next;

  logic [N_IN-1:0]    r_vec;
  logic [3:0]         r_settle_cnt;
  logic [N_IN-1:0]    r_stimulus;
  logic               r_pass;
  logic [N_IN:0]      r_fail_count;
  logic [N_IN-1:0]    r_first_fail;
  logic [2**N_IN-1:0] r_table;

  logic w_expected;
  logic w_mismatch;
  logic w_last;
  logic w_stop;
  logic w_busy;
  logic w_done;

  // Expected gate response for the vector currently being checked
  always_comb begin
    w_expected = 1'b0;
    case (GATE_OP)
      0:       w_expected = ~r_vec[0];
      1:       w_expected = &r_vec;
      2:       w_expected = |r_vec;
      3:       w_expected = ^r_vec;
      4:       w_expected = ~(&r_vec);
      5:       w_expected = ~(|r_vec);
      default: w_expected = 1'b0;
    endcase
  end

  assign w_mismatch = (dut_out != w_expected);
  assign w_last     = (r_vec == c_vec_last);

`ifdef STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_DRIVE;
      end
      S_DRIVE: begin
        if (c_settle_load == 4'd0) w_next = S_CHECK;
        else                       w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_settle_cnt <= 4'd1) w_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_last || w_stop) w_next = S_DONE;
        else                  w_next = S_DRIVE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec        <= '0;
      r_settle_cnt <= 4'd0;
      r_stimulus   <= '0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_table      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_vec        <= '0;
            r_pass       <= 1'b0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_table      <= '0;
          end
        end
        S_DRIVE: begin
          r_stimulus   <= r_vec;
          r_settle_cnt <= c_settle_load;
        end
        S_SETTLE: begin
          r_settle_cnt <= r_settle_cnt - 4'd1;
        end
        S_CHECK: begin
          r_table[r_vec] <= dut_out;
          if (w_mismatch) begin
            r_fail_count <= r_fail_count + c_fail_one;
            if (r_fail_count == '0) r_first_fail <= r_vec;
          end
          if (!(w_last || w_stop)) r_vec <= r_vec + c_vec_one;
        end
        S_DONE: begin
          // fail_count already includes the final CHECK by this cycle
          r_pass <= (r_fail_count == '0);
        end
        default: begin
          r_vec <= r_vec;
        end
      endcase
    end
  end

  assign stimulus       = r_stimulus;
  assign busy           = w_busy;
  assign done           = w_done;
  assign pass           = r_pass;
  assign fail_count     = r_fail_count;
  assign first_fail_vec = r_first_fail;
  assign table_out      = r_table;

endmodule

`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
// ============================================================================
// Module   : tb_gate_truth_checker
// Purpose  : Directed checks of gate_truth_checker in four configurations.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gate_truth_checker;

  logic clk;
  logic [3:0] rstn_v;
  logic [3:0] start_v;
  logic [3:0] done_v;
  logic mode_a;

  int n_checks;
  int n_errors;

  // Instance A: N_IN=1 NOT, SETTLE=2
  logic [0:0] stim_a, first_a;
  logic [1:0] fail_a, table_a;
  logic dout_a, busy_a, pass_a;
  // Instance B: N_IN=2 AND, SETTLE=0, fed by an OR gate
  logic [1:0] stim_b, first_b;
  logic [2:0] fail_b;
  logic [3:0] table_b;
  logic dout_b, busy_b, pass_b;
  // Instance C: N_IN=2 XOR, SETTLE=2, correct gate
  logic [1:0] stim_c, first_c;
  logic [2:0] fail_c;
  logic [3:0] table_c;
  logic dout_c, busy_c, pass_c;
  // Instance E: N_IN=2 OR, SETTLE=2, output stuck at 1
  logic [1:0] stim_e, first_e;
  logic [2:0] fail_e;
  logic [3:0] table_e;
  logic dout_e, busy_e, pass_e;

  assign dout_a = mode_a ? 1'b0 : ~stim_a[0];
  assign dout_b = |stim_b;
  assign dout_c = ^stim_c;
  assign dout_e = 1'b1;

`ifdef STOP_ON_FAIL_EN
  localparam int A0_CYC = 4,  B_CYC = 4,  B_FAIL = 1, E_CYC = 4;
  localparam int B_TAB  = 4'b0010, E_TAB = 4'b0001;
`else
  localparam int A0_CYC = 8,  B_CYC = 8,  B_FAIL = 2, E_CYC = 16;
  localparam int B_TAB  = 4'b1110, E_TAB = 4'b1111;
`endif

  gate_truth_checker #(.N_IN(1), .SETTLE(2), .GATE_OP(0)) u_a (
    .clk(clk), .rst_n(rstn_v[0]), .start(start_v[0]), .stimulus(stim_a),
    .dut_out(dout_a), .busy(busy_a), .done(done_v[0]), .pass(pass_a),
    .fail_count(fail_a), .first_fail_vec(first_a), .table_out(table_a));

  gate_truth_checker #(.N_IN(2), .SETTLE(0), .GATE_OP(1)) u_b (
    .clk(clk), .rst_n(rstn_v[1]), .start(start_v[1]), .stimulus(stim_b),
    .dut_out(dout_b), .busy(busy_b), .done(done_v[1]), .pass(pass_b),
    .fail_count(fail_b), .first_fail_vec(first_b), .table_out(table_b));

  gate_truth_checker #(.N_IN(2), .SETTLE(2), .GATE_OP(3)) u_c (
    .clk(clk), .rst_n(rstn_v[2]), .start(start_v[2]), .stimulus(stim_c),
    .dut_out(dout_c), .busy(busy_c), .done(done_v[2]), .pass(pass_c),
    .fail_count(fail_c), .first_fail_vec(first_c), .table_out(table_c));

  gate_truth_checker #(.N_IN(2), .SETTLE(2), .GATE_OP(2)) u_e (
    .clk(clk), .rst_n(rstn_v[3]), .start(start_v[3]), .stimulus(stim_e),
    .dut_out(dout_e), .busy(busy_e), .done(done_v[3]), .pass(pass_e),
    .fail_count(fail_e), .first_fail_vec(first_e), .table_out(table_e));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then count edges until done (bounded)
  task automatic launch(input int k, output int cycles);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    cycles = 0;
    while (!done_v[k] && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int n_done, e_first, e_second;
    logic busy9;
    n_checks = 0;
    n_errors = 0;
    rstn_v   = 4'b0000;
    start_v  = 4'b0000;
    mode_a   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stim",  32'(stim_a),  0);
    check("rst_busy",  32'(busy_a),  0);
    check("rst_table", 32'(table_b), 0);
    rstn_v = 4'b1111;
    @(negedge clk);
    check("idle_done", 32'(done_v),  0);
    check("idle_pass", 32'(pass_a),  0);

    // A: correct NOT gate
    launch(0, cyc);
    check("a_cycles", cyc, 8);
    check("a_stim_last", 32'(stim_a), 1);
    @(posedge clk); #1;
    check("a_done_drop", 32'(done_v[0]), 0);
    check("a_pass",  32'(pass_a),  1);
    check("a_fail",  32'(fail_a),  0);
    check("a_table", 32'(table_a), 2'b01);
    check("a_first", 32'(first_a), 0);

    // A: output stuck at 0
    mode_a = 1'b1;
    launch(0, cyc);
    check("a0_cycles", cyc, A0_CYC);
    @(posedge clk); #1;
    check("a0_pass",  32'(pass_a),  0);
    check("a0_fail",  32'(fail_a),  1);
    check("a0_first", 32'(first_a), 0);
    check("a0_table", 32'(table_a), 2'b00);
    mode_a = 1'b0;

    // B: AND checker observing an OR gate, no settle time
    launch(1, cyc);
    check("b_cycles", cyc, B_CYC);
    @(posedge clk); #1;
    check("b_pass",  32'(pass_b),  0);
    check("b_fail",  32'(fail_b),  B_FAIL);
    check("b_first", 32'(first_b), 2'b01);
    check("b_table", 32'(table_b), B_TAB);

    // C: reset asserted during the second CHECK, then a clean run
    @(negedge clk);
    start_v[2] = 1'b1;
    @(posedge clk); #1;
    start_v[2] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("c_busy_mid", 32'(busy_c), 1);
    check("c_stim_mid", 32'(stim_c), 2'b01);
    rstn_v[2] = 1'b0;
    #1;
    check("c_rst_busy",  32'(busy_c),  0);
    check("c_rst_stim",  32'(stim_c),  0);
    check("c_rst_table", 32'(table_c), 0);
    check("c_rst_fail",  32'(fail_c),  0);
    repeat (3) @(posedge clk);
    #1;
    check("c_rst_nodone", 32'(done_v[2]), 0);
    @(negedge clk);
    rstn_v[2] = 1'b1;
    launch(2, cyc);
    check("c_cycles", cyc, 16);
    @(posedge clk); #1;
    check("c_pass",  32'(pass_c),  1);
    check("c_fail",  32'(fail_c),  0);
    check("c_table", 32'(table_c), 4'b0110);

    // A: start held across two runs plus an ignored mid-run pulse
    n_done = 0; e_first = -1; e_second = -1; busy9 = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      start_v[0] = (e <= 10) || (e == 14);
      @(posedge clk); #1;
      if (done_v[0]) begin
        if (n_done == 0)      e_first  = e;
        else if (n_done == 1) e_second = e;
        n_done++;
      end
      if (e == 9) busy9 = busy_a;
    end
    start_v[0] = 1'b0;
    check("d_ndone",   n_done,   2);
    check("d_first",   e_first,  8);
    check("d_second",  e_second, 18);
    check("d_idle_gap", 32'(busy9), 0);
    check("d_idle_end", 32'(busy_a), 0);
    check("d_pass",    32'(pass_a), 1);

    // E: OR checker with output stuck at 1
    launch(3, cyc);
    check("e_cycles", cyc, E_CYC);
    @(posedge clk); #1;
    check("e_pass",  32'(pass_e),  0);
    check("e_fail",  32'(fail_e),  1);
    check("e_first", 32'(first_e), 0);
    check("e_table", 32'(table_e), E_TAB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
